usb_uart_bridge_ctrl: RTL and testbench

- Sits between the USB CDC byte streams and the UART TX/RX pair in the TT USB-serial top.
- Buffers each direction in a small FIFO and sequences the UART transmitter handshake.
- Provides a loopback mode: OUT bytes return on IN, with a round-robin arbiter sharing the IN-side FIFO between loopback traffic and UART RX traffic.
- Keeps a saturating count of UART RX bytes dropped on overflow.

---
 rtl/usb_uart_bridge_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_usb_uart_bridge_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_uart_bridge_ctrl.sv
// USB CDC <-> UART bridge controller: per-direction byte FIFOs, UART TX launch FSM,
// and a loopback mode that shares the IN-side FIFO between UART RX and OUT bytes.

module usb_uart_bridge_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  // Fullness comes from the registered level, so a same-cycle pop never admits a push.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  // NOTE: storage is deliberately not reset; the reset pointers/level make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

module usb_uart_bridge_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          loopback_i,
  input  logic [7:0]                    out_data_i,
  input  logic                          out_valid_i,
  output logic                          out_ready_o,
  output logic [7:0]                    in_data_o,
  output logic                          in_valid_o,
  input  logic                          in_ready_i,
  output logic [7:0]                    uart_tx_data_o,
  output logic                          uart_tx_en_o,
  input  logic                          uart_tx_busy_i,
  input  logic [7:0]                    uart_rx_data_i,
  input  logic                          uart_rx_valid_i,
  output logic                          uart_rx_read_o,
  output logic                          mode_o,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level_o,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level_o,
  output logic [CNT_W-1:0]              drop_cnt_o
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_HI, S_WAIT_LO} tx_state_e;
  typedef enum logic {RR_UART, RR_LOOP} rr_e;

  tx_state_e        state_q, state_d;
  rr_e              rr_q, rr_d, grant;
  logic             mode_q, mode_d;
  logic [1:0]       wait_cnt_q, wait_cnt_d;
  logic [7:0]       tx_last_q;
  logic [CNT_W-1:0] drop_cnt_q;

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_push_data;
  logic       drop, out_xfer;

  usb_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(tx_push), .pop_i(tx_pop), .data_i(out_data_i),
    .data_o(tx_head), .level_o(tx_level_o), .full_o(tx_full), .empty_o(tx_empty)
  );

  usb_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(rx_push), .pop_i(rx_pop), .data_i(rx_push_data),
    .data_o(in_data_o), .level_o(rx_level_o), .full_o(rx_full), .empty_o(rx_empty)
  );

  assign in_valid_o = !rx_empty;
  assign rx_pop     = in_valid_o && in_ready_i;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    out_ready_o    = 1'b0;
    tx_push        = 1'b0;
    rx_push        = 1'b0;
    rx_push_data   = uart_rx_data_i;
    uart_rx_read_o = 1'b0;
    drop           = 1'b0;
    rr_d           = rr_q;
    grant          = RR_UART;
    if (!mode_q) begin
      out_ready_o    = !tx_full;
      tx_push        = out_valid_i && !tx_full;
      uart_rx_read_o = uart_rx_valid_i;
      rx_push        = uart_rx_valid_i && !rx_full;
      drop           = uart_rx_valid_i && rx_full;
    end else if (rx_full) begin
      uart_rx_read_o = uart_rx_valid_i;
      drop           = uart_rx_valid_i;
    end else begin
      if (uart_rx_valid_i && out_valid_i) begin
        grant = (rr_q == RR_UART) ? RR_LOOP : RR_UART;
        rr_d  = grant;
      end else if (out_valid_i) begin
        grant = RR_LOOP;
      end
      out_ready_o = !uart_rx_valid_i || (grant == RR_LOOP);
      if (grant == RR_LOOP) begin
        rx_push      = out_valid_i;
        rx_push_data = out_data_i;
      end else begin
        rx_push        = uart_rx_valid_i;
        uart_rx_read_o = uart_rx_valid_i;
      end
    end
  end

  // Mode only switches when nothing is queued or in flight towards the UART.
  assign out_xfer = out_valid_i && out_ready_o;
  assign mode_d   = (tx_empty && state_q == S_IDLE && !out_xfer) ? loopback_i : mode_q;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    tx_pop       = 1'b0;
    uart_tx_en_o = 1'b0;
    unique case (state_q)
      S_IDLE: if (!tx_empty && !uart_tx_busy_i) state_d = S_LOAD;
      S_LOAD: begin
        uart_tx_en_o = 1'b1;
        tx_pop       = 1'b1;
        wait_cnt_d   = '0;
        state_d      = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // Give up after four cycles without busy so a dead transmitter cannot stall the FIFO.
        if (uart_tx_busy_i)         state_d = S_WAIT_LO;
        else if (wait_cnt_q == 2'd3) state_d = S_IDLE;
        else                         wait_cnt_d = wait_cnt_q + 2'd1;
      end
      S_WAIT_LO: if (!uart_tx_busy_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign uart_tx_data_o = (state_q == S_LOAD) ? tx_head : tx_last_q;
  assign mode_o         = mode_q;
  assign drop_cnt_o     = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_q       <= RR_UART;
      mode_q     <= 1'b0;
      wait_cnt_q <= '0;
      tx_last_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      mode_q     <= mode_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_q == S_LOAD) tx_last_q <= tx_head;
      if (drop && drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_usb_uart_bridge_ctrl.sv
// Directed bench for usb_uart_bridge_ctrl with a UART busy model and output monitors.
module tb_usb_uart_bridge_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       loopback_i;
  logic [7:0] out_data_i;
  logic       out_valid_i;
  logic       out_ready_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i;
  logic [7:0] uart_tx_data_o;
  logic       uart_tx_en_o;
  logic       uart_tx_busy_i;
  logic [7:0] uart_rx_data_i;
  logic       uart_rx_valid_i;
  logic       uart_rx_read_o;
  logic       mode_o;
  logic [2:0] tx_level_o;
  logic [2:0] rx_level_o;
  logic [7:0] drop_cnt_o;

  usb_uart_bridge_ctrl #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .loopback_i(loopback_i),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .uart_tx_data_o(uart_tx_data_o), .uart_tx_en_o(uart_tx_en_o), .uart_tx_busy_i(uart_tx_busy_i),
    .uart_rx_data_i(uart_rx_data_i), .uart_rx_valid_i(uart_rx_valid_i), .uart_rx_read_o(uart_rx_read_o),
    .mode_o(mode_o), .tx_level_o(tx_level_o), .rx_level_o(rx_level_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  // UART transmitter model: busy for 10 cycles after each start pulse unless muted.
  logic busy_hold = 1'b0;
  logic busy_mute = 1'b0;
  int   busy_cnt  = 0;
  assign uart_tx_busy_i = busy_hold || (busy_cnt != 0 && !busy_mute);

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         en_busy = 0;
  int         en_dbl  = 0;
  int         rd_cnt  = 0;
  logic       prev_en = 1'b0;
  logic [7:0] tx_q[$];
  logic [7:0] in_q[$];
  int         en_cyc[$];

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_en <= uart_tx_en_o;
    if (uart_tx_en_o) begin
      tx_q.push_back(uart_tx_data_o);
      en_cyc.push_back(cyc);
      if (uart_tx_busy_i) en_busy <= en_busy + 1;
      if (prev_en)        en_dbl  <= en_dbl + 1;
    end
    if (uart_rx_read_o) rd_cnt <= rd_cnt + 1;
    if (in_valid_o && in_ready_i) in_q.push_back(in_data_o);
    if (uart_tx_en_o)       busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_out(input logic [7:0] d);
    int   n    = 0;
    logic done = 1'b0;
    out_valid_i = 1'b1;
    out_data_i  = d;
    while (!done && n < 300) begin
      #1;
      done = out_ready_o;
      @(posedge clk);
      #2;
      n++;
    end
    out_valid_i = 1'b0;
    check("send_out_accepted", 32'(done), 32'd1);
  endtask

  initial begin
    int  tb, ib, rb, base, lsent, usent;
    logic r, u;

    rst_n = 1'b0; loopback_i = 1'b0; out_data_i = '0; out_valid_i = 1'b0;
    in_ready_i = 1'b0; uart_rx_data_i = '0; uart_rx_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_out_ready", 32'(out_ready_o), 32'd1);
    check("rst_in_valid",  32'(in_valid_o), 32'd0);
    check("rst_tx_en",     32'(uart_tx_en_o), 32'd0);
    check("rst_rx_read",   32'(uart_rx_read_o), 32'd0);
    check("rst_mode",      32'(mode_o), 32'd0);
    check("rst_tx_level",  32'(tx_level_o), 32'd0);
    check("rst_rx_level",  32'(rx_level_o), 32'd0);
    check("rst_drop",      32'(drop_cnt_o), 32'd0);
    tick();

    // Bridge TX: three back-to-back bytes, launch latency 2 cycles.
    tb = tx_q.size();
    send_out(8'h41);
    check("lat_no_en_yet", 32'(uart_tx_en_o), 32'd0);
    send_out(8'h42);
    check("lat_en", 32'(uart_tx_en_o), 32'd1);
    check("lat_data", 32'(uart_tx_data_o), 32'h41);
    send_out(8'h43);
    repeat (60) tick();
    check("t1_count", 32'(tx_q.size() - tb), 32'd3);
    for (int i = 0; i < 3 && tb + i < tx_q.size(); i++)
      check("t1_data", 32'(tx_q[tb+i]), 32'h41 + 32'(i));
    check("t1_tx_level", 32'(tx_level_o), 32'd0);

    // Bridge TX backpressure: hold busy, fill FIFO, then release.
    tb = tx_q.size();
    busy_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      out_valid_i = 1'b1;
      out_data_i  = 8'h50 + 8'(i);
      tick();
    end
    #1;
    check("t2_ready_low", 32'(out_ready_o), 32'd0);
    check("t2_level4", 32'(tx_level_o), 32'd4);
    busy_hold = 1'b0;
    send_out(8'h54);
    send_out(8'h55);
    repeat (110) tick();
    check("t2_count", 32'(tx_q.size() - tb), 32'd6);
    for (int i = 0; i < 6 && tb + i < tx_q.size(); i++)
      check("t2_data", 32'(tx_q[tb+i]), 32'h50 + 32'(i));
    check("t2_no_en_while_busy", 32'(en_busy), 32'd0);
    check("t2_single_cycle_en", 32'(en_dbl), 32'd0);

    // Bridge RX: six bytes into a 4-deep FIFO with no consumer.
    rb = rd_cnt;
    ib = in_q.size();
    for (int i = 0; i < 6; i++) begin
      uart_rx_valid_i = 1'b1;
      uart_rx_data_i  = 8'h60 + 8'(i);
      if (i == 0) begin
        #1;
        check("t3_read_comb", 32'(uart_rx_read_o), 32'd1);
        @(posedge clk);
        #2;
      end else begin
        tick();
      end
    end
    uart_rx_valid_i = 1'b0;
    #1;
    check("t3_rx_level", 32'(rx_level_o), 32'd4);
    check("t3_drop", 32'(drop_cnt_o), 32'd2);
    check("t3_reads", 32'(rd_cnt - rb), 32'd6);
    in_ready_i = 1'b1;
    repeat (6) tick();
    check("t3_drained", 32'(in_q.size() - ib), 32'd4);
    for (int i = 0; i < 4 && ib + i < in_q.size(); i++)
      check("t3_data", 32'(in_q[ib+i]), 32'h60 + 32'(i));

    // Mode latch waits for the TX FIFO and FSM to go quiet.
    tb = tx_q.size();
    busy_hold = 1'b1;
    send_out(8'h70);
    send_out(8'h71);
    loopback_i = 1'b1;
    tick();
    check("t5_mode_held", 32'(mode_o), 32'd0);
    busy_hold = 1'b0;
    for (int n = 0; n < 100 && !mode_o; n++) tick();
    check("t5_mode_set", 32'(mode_o), 32'd1);
    check("t5_tx_empty", 32'(tx_level_o), 32'd0);
    check("t5_launched", 32'(tx_q.size() - tb), 32'd2);
    if (tx_q.size() - tb == 2) begin
      check("t5_data0", 32'(tx_q[tb]), 32'h70);
      check("t5_data1", 32'(tx_q[tb+1]), 32'h71);
    end

    // Loopback with both requesters contending: strict alternation, LOOP first.
    ib = in_q.size();
    rb = rd_cnt;
    lsent = 0;
    usent = 0;
    for (int c = 0; c < 10; c++) begin
      out_valid_i     = 1'b1;
      out_data_i      = 8'h10 + 8'(lsent);
      uart_rx_valid_i = 1'b1;
      uart_rx_data_i  = 8'hA0 + 8'(usent);
      #1;
      r = out_ready_o;
      u = uart_rx_read_o;
      check("t4_one_grant", 32'(r ^ u), 32'd1);
      @(posedge clk);
      #2;
      if (r) lsent++;
      if (u) usent++;
    end
    out_valid_i = 1'b0;
    uart_rx_valid_i = 1'b0;
    repeat (4) tick();
    check("t4_loop_sent", 32'(lsent), 32'd5);
    check("t4_uart_sent", 32'(usent), 32'd5);
    check("t4_uart_reads", 32'(rd_cnt - rb), 32'd5);
    check("t4_drop_unchanged", 32'(drop_cnt_o), 32'd2);
    check("t4_in_count", 32'(in_q.size() - ib), 32'd10);
    for (int j = 0; j < 10 && ib + j < in_q.size(); j++)
      check("t4_order", 32'(in_q[ib+j]), (j % 2 == 0) ? 32'h10 + 32'(j/2) : 32'hA0 + 32'(j/2));
    check("t4_tx_untouched", 32'(tx_level_o), 32'd0);

    // Back to bridge, saturate the drop counter, park both FIFOs at 3, then reset.
    loopback_i = 1'b0;
    tick();
    check("t6_mode_bridge", 32'(mode_o), 32'd0);
    in_ready_i = 1'b0;
    uart_rx_valid_i = 1'b1;
    uart_rx_data_i  = 8'h33;
    repeat (270) tick();
    uart_rx_valid_i = 1'b0;
    check("t6_drop_sat", 32'(drop_cnt_o), 32'd255);
    check("t6_rx_full", 32'(rx_level_o), 32'd4);
    in_ready_i = 1'b1;
    tick();
    in_ready_i = 1'b0;
    check("t6_rx_level3", 32'(rx_level_o), 32'd3);
    busy_hold = 1'b1;
    send_out(8'h81);
    send_out(8'h82);
    send_out(8'h83);
    check("t6_tx_level3", 32'(tx_level_o), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_tx_level0", 32'(tx_level_o), 32'd0);
    check("t6_rx_level0", 32'(rx_level_o), 32'd0);
    check("t6_in_valid0", 32'(in_valid_o), 32'd0);
    check("t6_mode0", 32'(mode_o), 32'd0);
    check("t6_drop0", 32'(drop_cnt_o), 32'd0);
    check("t6_out_ready", 32'(out_ready_o), 32'd1);
    tick();

    // Transmitter never raises busy: WAIT_HI times out, next launch 6 cycles later.
    busy_hold = 1'b0;
    busy_mute = 1'b1;
    base = en_cyc.size();
    send_out(8'h91);
    send_out(8'h92);
    repeat (20) tick();
    check("t7_launches", 32'(en_cyc.size() - base), 32'd2);
    if (en_cyc.size() - base == 2) begin
      check("t7_spacing", 32'(en_cyc[base+1] - en_cyc[base]), 32'd6);
      check("t7_data", 32'(tx_q[tx_q.size()-1]), 32'h92);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
